arb4_rr: RTL and testbench

ARB4_RR -- requirements
Module: arb4_rr

---
 rtl/arb4_pkg.sv | 13 +
 rtl/arb4_rr_pick.sv | 27 ++
 rtl/arb4_rr.sv | 111 +++++++++++
 tb/tb_arb4_rr.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/arb4_pkg.sv
// Shared constants and types for the 4-way round-robin arbiter.
package arb4_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int HOLD_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

endpackage

// File: rtl/arb4_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_start, wrapping.
module rr_pick
    import arb4_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_start,
    output logic [ID_W-1:0]    o_win,
    output logic               o_found
);

    logic [ID_W-1:0] w_idx;

    // Walk from the farthest offset back to offset 0 so the nearest hit is assigned last.
    always_comb begin
        o_win   = '0;
        o_found = 1'b0;
        w_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = i_start + ID_W'(k);
            if (i_req[w_idx]) begin
                o_win   = w_idx;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb4_rr.sv
// 4-requester round-robin arbiter with per-owner hold timeout.
// Optional macro ARB4_RR_LOCK_EN adds a lock input that suppresses the timeout for the owner.
module arb4_rr
    import arb4_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
`ifdef ARB4_RR_LOCK_EN
    input  logic [NUM_REQ-1:0] lock,
`endif
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid
);

    localparam logic [HOLD_W-1:0] MAX_CNT = HOLD_W'(MAX_HOLD);

    state_t              r_state, w_state_nxt;
    logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
    logic [ID_W-1:0]     r_gnt_id, w_gnt_id_nxt;
    logic                r_gnt_valid;
    logic [HOLD_W-1:0]   r_hold_cnt, w_hold_nxt;
    logic [ID_W-1:0]     r_last, w_last_nxt;

    logic [ID_W-1:0]     w_start;
    logic [ID_W-1:0]     w_win;
    logic                w_found;
    logic                w_timeout;

    // While owned, the scan starts after the departing owner; a lone timed-out owner wraps back to itself.
    assign w_start = ((r_state == OWNED) ? r_gnt_id : r_last) + ID_W'(1);

`ifdef ARB4_RR_LOCK_EN
    assign w_timeout = (r_hold_cnt == MAX_CNT) && !lock[r_gnt_id];
`else
    assign w_timeout = (r_hold_cnt == MAX_CNT);
`endif

    rr_pick u_pick (
        .i_req   (req),
        .i_start (w_start),
        .o_win   (w_win),
        .o_found (w_found)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_hold_nxt   = r_hold_cnt;
        w_last_nxt   = r_last;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt  = OWNED;
                    w_gnt_nxt    = NUM_REQ'(1) << w_win;
                    w_gnt_id_nxt = w_win;
                    w_hold_nxt   = HOLD_W'(1);
                end
            end
            OWNED: begin
                if (req[r_gnt_id] && !w_timeout) begin
                    // Saturate: only reachable past MAX_CNT when the owner holds a lock.
                    if (r_hold_cnt != MAX_CNT) w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end else begin
                    w_last_nxt = r_gnt_id;
                    if (w_found) begin
                        w_gnt_nxt    = NUM_REQ'(1) << w_win;
                        w_gnt_id_nxt = w_win;
                        w_hold_nxt   = HOLD_W'(1);
                    end else begin
                        w_state_nxt  = IDLE;
                        w_gnt_nxt    = '0;
                        w_gnt_id_nxt = '0;
                        w_hold_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_hold_cnt  <= '0;
            r_last      <= ID_W'(NUM_REQ - 1);
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_gnt_valid <= |w_gnt_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_last      <= w_last_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_arb4_rr.sv
// Directed + randomized bench for arb4_rr against a behavioural round-robin model.
module tb_arb4_rr;

    localparam int MAXH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;

    int ncmp  = 0;
    int nfail = 0;

    // Reference model: owner (-1 = nobody), cycles held, last departed owner.
    int m_owner;
    int m_held;
    int m_last;

    always #5 clk = ~clk;

    arb4_rr #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
`ifdef ARB4_RR_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    task model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 3;
    endtask

    task model_search(input int from);
        m_owner = -1;
        for (int k = 0; k < 4; k++) begin
            if (m_owner < 0 && req[(from + k) % 4]) begin
                m_owner = (from + k) % 4;
                m_held  = 1;
            end
        end
    endtask

    task model_step();
        bit locked;
        locked = 1'b0;
`ifdef ARB4_RR_LOCK_EN
        if (m_owner >= 0) locked = lock[m_owner];
`endif
        if (m_owner < 0) begin
            model_search(m_last + 1);
        end else if (req[m_owner] && (m_held < MAXH || locked)) begin
            m_held = (m_held < MAXH) ? m_held + 1 : MAXH;
        end else begin
            m_last = m_owner;
            model_search(m_owner + 1);
            if (m_owner < 0) m_held = 0;
        end
    endtask

    task check(input string tag);
        logic [3:0] e_gnt;
        logic       e_vld;
        e_gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        e_vld = (m_owner >= 0);
        ncmp++;
        assert (gnt === e_gnt) else begin
            nfail++;
            $error("FAIL %s gnt got %b want %b", tag, gnt, e_gnt);
        end
        ncmp++;
        assert (gnt_valid === e_vld) else begin
            nfail++;
            $error("FAIL %s gnt_valid got %b want %b", tag, gnt_valid, e_vld);
        end
        if (m_owner >= 0) begin
            ncmp++;
            assert (gnt_id === 2'(m_owner)) else begin
                nfail++;
                $error("FAIL %s gnt_id got %0d want %0d", tag, gnt_id, m_owner);
            end
        end
    endtask

    task tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check(tag);
    endtask

    task do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        lock  = 4'b0000;
        model_reset();
        #2;
        check("reset_state");
        ncmp++;
        assert (gnt_id === 2'd0) else begin
            nfail++;
            $error("FAIL reset_gnt_id got %0d want 0", gnt_id);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // No request after reset: no grant.
        tick("idle0");
        tick("idle1");

        // Single requester 0: granted one cycle later.
        req = 4'b0001;
        tick("first_gnt");
        req = 4'b0000;
        tick("release_idle");
        tick("stay_idle");

        // Async reset mid-grant, then req=1000 grants 3 first.
        req = 4'b0110;
        tick("pre_rst0");
        tick("pre_rst1");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1000;
        tick("post_rst_gnt");

        // All requesting: rotation 0,1,2,3,0 at MAX_HOLD cycles each.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 4 * MAXH + 4; i++) tick("rotate");

        // Owner 2 drops after 3 cycles while 0 waits.
        do_reset();
        req = 4'b0100;
        tick("own2_a");
        req = 4'b0101;
        tick("own2_b");
        tick("own2_c");
        req = 4'b0001;
        tick("handoff_0");
        req = 4'b1111;
        for (int i = 0; i < MAXH + 2; i++) tick("after_handoff");

        // Lone requester 1: re-granted on timeout, never dropped.
        do_reset();
        req = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            tick("lone_req1");
            ncmp++;
            assert (gnt === 4'b0010) else begin
                nfail++;
                $error("FAIL lone_nogap gnt got %b want 0010", gnt);
            end
        end

`ifdef ARB4_RR_LOCK_EN
        // Lock on owner 0 suppresses the timeout.
        do_reset();
        req  = 4'b0011;
        lock = 4'b0001;
        for (int i = 0; i < MAXH + 5; i++) tick("lock_hold");
        req = 4'b0010;
        tick("lock_release");
        lock = 4'b1110;
        req  = 4'b0011;
        for (int i = 0; i < MAXH + 2; i++) tick("nonowner_lock");
        lock = 4'b0000;
`endif

        // Random traffic with sticky requests so holds and timeouts both occur.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
`ifdef ARB4_RR_LOCK_EN
            if ($urandom_range(0, 7) == 0) lock = 4'($urandom_range(0, 15));
`endif
            tick("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
